// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned double buffering; all outputs registered (1 cycle).
// No backpressure: scanning is free-running. Macro LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int WIDTH        = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*WIDTH-1:0]   digits_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [WIDTH-1:0]              nibble_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic                          frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = NUM_DIGITS * WIDTH;
    localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         active_q, active_d;
    logic                  pending_q, pending_d;
    logic [WIDTH-1:0]      nibble_q, nibble_d;
    logic [IW-1:0]         sel_q, sel_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  done_q, done_d;
    logic                  slot_end;
    logic                  boundary;
    logic                  lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
    // lz_vec[k] is set when digit k and everything above it are zero.
    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  lz_run;

    always_comb begin
        lz_vec = '0;
        lz_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run    = lz_run & (active_q[k*WIDTH +: WIDTH] == '0);
            lz_vec[k] = lz_run;
        end
    end

    assign lz_blank = lz_vec[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    assign slot_end = (div_cnt_q == DIV_LAST);
    assign boundary = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary) begin
            // A load landing on the boundary itself is newer than the shadow copy.
            if (load) begin
                active_d = digits_in;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end

        nibble_d = active_q[idx_q*WIDTH +: WIDTH];
        sel_d    = idx_q;
        anode_d  = '1;
        if ((div_cnt_q >= BLANK_END) && digit_en[idx_q] && !lz_blank) begin
            anode_d[idx_q] = 1'b0;
        end
        done_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            nibble_q  <= '0;
            sel_q     <= '0;
            anode_q   <= '1;
            done_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            nibble_q  <= nibble_d;
            sel_q     <= sel_d;
            anode_q   <= anode_d;
            done_q    <= done_d;
        end
    end

    assign nibble_out = nibble_q;
    assign digit_sel  = sel_q;
    assign anode_n    = anode_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-position model plus hand-computed checkpoints.
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int W  = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   digits_in;
    logic          load;
    logic [3:0]    digit_en;
    logic [3:0]    nibble_out;
    logic [1:0]    digit_sel;
    logic [3:0]    anode_n;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int n = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .WIDTH(W), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
        .digit_en(digit_en), .nibble_out(nibble_out), .digit_sel(digit_sel),
        .anode_n(anode_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d actual=%0h expected=%0h", name, n, act, exp);
        end
    endtask

    // Model: position in the scan is derived from cycles elapsed since reset release.
    int          t = 0;
    logic [15:0] m_active = '0, m_shadow = '0;
    bit          m_pending = 0;
    logic [3:0]  e_nib, e_an;
    logic [1:0]  e_sel;
    logic        e_fd;

    function automatic bit lz_dark(input int idx, input logic [15:0] val);
`ifdef LEADING_ZERO_BLANK_EN
        return (idx > 0) && ((val >> (idx * W)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t = 0; m_active = '0; m_shadow = '0; m_pending = 0;
            e_nib = '0; e_sel = '0; e_an = 4'hF; e_fd = 1'b0;
        end else begin
            int div, idx;
            bit bnd;
            div   = t % RD;
            idx   = (t / RD) % ND;
            bnd   = (div == RD - 1) && (idx == ND - 1);
            e_nib = 4'((m_active >> (idx * W)) & 16'hF);
            e_sel = 2'(idx);
            e_an  = ((div >= BC) && digit_en[idx] && !lz_dark(idx, m_active))
                    ? ~(4'b0001 << idx) : 4'hF;
            e_fd  = bnd;
            if (bnd) begin
                if (load) m_active = digits_in;
                else if (m_pending) m_active = m_shadow;
                m_pending = 0;
            end else if (load) begin
                m_shadow  = digits_in;
                m_pending = 1;
            end
            t++;
        end
        #1;
        chk("mdl_nibble", 32'(nibble_out), 32'(e_nib));
        chk("mdl_sel", 32'(digit_sel), 32'(e_sel));
        chk("mdl_anode", 32'(anode_n), 32'(e_an));
        chk("mdl_done", 32'(frame_done), 32'(e_fd));
    end

    task automatic adv(input int upto);
        while (n < upto) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_load(input logic [15:0] val);
        digits_in = val;
        load = 1'b1;
        adv(n + 1);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; digits_in = '0; digit_en = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_anode", 32'(anode_n), 32'hF);
        chk("rst_sel", 32'(digit_sel), 32'h0);
        chk("rst_nib", 32'(nibble_out), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        n = 0;

        // Plain scan after reset
        adv(1);  chk("s_blank0", 32'(anode_n), 32'hF); chk("s_sel0", 32'(digit_sel), 32'h0);
        adv(2);  chk("s_lit0", 32'(anode_n), 32'hE);   chk("s_nib0", 32'(nibble_out), 32'h0);
        adv(6);  chk("s_lit1", 32'(anode_n), 32'hD);   chk("s_sel1", 32'(digit_sel), 32'h1);
        adv(15); chk("fd_before", 32'(frame_done), 32'h0);
        adv(16); chk("fd_pulse", 32'(frame_done), 32'h1);
        adv(17); chk("fd_after", 32'(frame_done), 32'h0);

        // Mid-frame load appears only after the boundary
        adv(20); pulse_load(16'h1234);
        adv(26); chk("no_tear", 32'(nibble_out), 32'h0);
        adv(32); chk("fd_frame2", 32'(frame_done), 32'h1);
        adv(34); chk("f2_d0", 32'(nibble_out), 32'h4); chk("f2_an0", 32'(anode_n), 32'hE);
        adv(38); chk("f2_d1", 32'(nibble_out), 32'h3);
        adv(46); chk("f2_d3", 32'(nibble_out), 32'h1);

        // Last load before the boundary wins
        adv(50); pulse_load(16'hAAAA);
        adv(55); pulse_load(16'h5678);
        adv(58); chk("old_kept", 32'(nibble_out), 32'h2);
        adv(66); chk("last_d0", 32'(nibble_out), 32'h8);
        adv(78); chk("last_d3", 32'(nibble_out), 32'h5);

        // Load on the boundary cycle, then a masked digit
        adv(79); pulse_load(16'h9ABC);
        adv(81); chk("bnd_nib", 32'(nibble_out), 32'hC); chk("bnd_blank", 32'(anode_n), 32'hF);
        adv(82); chk("bnd_lit", 32'(anode_n), 32'hE);
        adv(85); digit_en = 4'b1011;
        adv(90); chk("mask_an2", 32'(anode_n), 32'hF); chk("mask_sel2", 32'(digit_sel), 32'h2);
                 chk("mask_nib2", 32'(nibble_out), 32'hA);
        adv(94); chk("mask_an3", 32'(anode_n), 32'h7); chk("mask_nib3", 32'(nibble_out), 32'h9);

        // Reset mid-frame with a pending load
        adv(96);  digit_en = 4'hF;
        adv(100); pulse_load(16'hFEED);
        adv(105); chk("pre_rst_sel", 32'(digit_sel), 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("arst_anode", 32'(anode_n), 32'hF);
        chk("arst_sel", 32'(digit_sel), 32'h0);
        chk("arst_nib", 32'(nibble_out), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        adv(2);  chk("rs_sel", 32'(digit_sel), 32'h0); chk("rs_an", 32'(anode_n), 32'hE);
        adv(34); chk("rs_discard", 32'(nibble_out), 32'h0);

        // Leading zeros
        adv(40); pulse_load(16'h0070);
        adv(50); chk("lz_an0", 32'(anode_n), 32'hE); chk("lz_nib0", 32'(nibble_out), 32'h0);
        adv(54); chk("lz_an1", 32'(anode_n), 32'hD); chk("lz_nib1", 32'(nibble_out), 32'h7);
`ifdef LEADING_ZERO_BLANK_EN
        adv(58); chk("lz_an2", 32'(anode_n), 32'hF);
        adv(62); chk("lz_an3", 32'(anode_n), 32'hF);
`else
        adv(58); chk("lz_an2", 32'(anode_n), 32'hB);
        adv(62); chk("lz_an3", 32'(anode_n), 32'h7);
`endif
        adv(64); pulse_load(16'h0000);
        adv(82); chk("z_an0", 32'(anode_n), 32'hE);
`ifdef LEADING_ZERO_BLANK_EN
        adv(86); chk("z_an1", 32'(anode_n), 32'hF);
        adv(90); chk("z_an2", 32'(anode_n), 32'hF);
`else
        adv(86); chk("z_an1", 32'(anode_n), 32'hD);
        adv(90); chk("z_an2", 32'(anode_n), 32'hB);
`endif
        adv(92);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan controller for the multi-digit 7-segment display. Each refresh slot selects one nibble from a double-buffered digit register and drives it to the downstream mux/decoder. It also drives the active-low anode enable for that digit. New values are taken via a load strobe and applied only at frame boundaries, so a displayed number never tears mid-scan.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (>= 2)
WIDTH, 4, bits per digit nibble
REFRESH_DIV, 100000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 1000, anti-ghosting dead time at slot start, anodes all off (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
digits_in  input  NUM_DIGITS*WIDTH  new display value; digit k is bits [k*WIDTH +: WIDTH], digit 0 rightmost
load  input  1  capture digits_in into shadow register this cycle
digit_en  input  NUM_DIGITS  per-digit enable mask, sampled live; 0 = digit dark
nibble_out  output  WIDTH  nibble for currently scanned digit (to mux/decoder)
digit_sel  output  $clog2(NUM_DIGITS)  index of scanned digit
anode_n  output  NUM_DIGITS  active-low anode enables, at most one bit low
frame_done  output  1  one-cycle pulse after last digit slot completes

Behaviour:
- Reset, async assert, all cleared immediately: div_cnt=0, idx=0, shadow=0, active=0, pending=0; outputs nibble_out=0, digit_sel=0, anode_n=all 1s, frame_done=0.
- div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, idx increments; idx NUM_DIGITS-1 wraps to 0.
- Frame boundary = cycle with div_cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
- All outputs are registered: they reflect the div_cnt/idx values of the previous cycle (1-cycle latency).
- nibble_out = active[idx]. digit_sel = idx.
- anode_n = all 1s when div_cnt < BLANK_CYCLES, or when digit_en[idx]==0, or when the digit is blanked by the optional feature. Otherwise only bit idx is low.
- load without boundary: shadow <= digits_in, pending <= 1. A repeated load before the boundary overwrites shadow, and the last one wins.
- Boundary with pending=1 and no load: active <= shadow, pending <= 0.
- load on the boundary cycle: active <= digits_in directly and pending <= 0. The same-cycle value takes priority over the older shadow.
- frame_done = 1 for exactly the cycle after each boundary, independent of pending.
- Reset mid-frame: scan restarts at digit 0, slot start. Any pending load is discarded.
- Free-running: there is no idle state, and scanning starts the first cycle after reset deasserts.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: a digit k > 0 is blanked (anode_n all 1s in its slot) when active digit k and every more-significant active digit are 0. Digit 0 is never blanked. Blanking uses the active register, not shadow.
- Undefined: every enabled digit is shown, including leading zeros, and no blanking logic is synthesized.

Test Plan (NUM_DIGITS=4, WIDTH=4, REFRESH_DIV=4, BLANK_CYCLES=1):
1. Reset held, then released with digit_en=4'b1111 and no load -> anode_n=4'b1111 during reset. After release the scan runs digit_sel 0,1,2,3 with 4 cycles per slot: anode_n is 1111 for 1 cycle, then the idx bit is low for 3 cycles, and nibble_out=0 throughout.
2. load with digits_in=16'h1234 mid-frame -> nibble_out stays 0 until the frame boundary. Next frame: digit_sel 0..3 gives nibble_out 4,3,2,1. frame_done pulses once per 16 cycles.
3. load 16'hAAAA, then load 16'h5678 later in the same frame -> next frame shows 8,7,6,5. 16'hAAAA never appears.
4. load 16'h9ABC asserted exactly on the boundary cycle -> the very next slot shows nibble_out=C. Then, with digit_en=4'b1011, digit 2's slot shows anode_n=4'b1111.
5. Assert reset while digit_sel=2 with a load pending -> outputs clear asynchronously. After release, the scan restarts at digit 0 and the pending value is never displayed.
6. With LEADING_ZERO_BLANK_EN defined, load 16'h0070 -> digits 3 and 2 are dark, digit 1 shows 7, digit 0 shows 0. Load 16'h0000 -> only digit 0 is lit.
